// File: rtl/seq_multiplier32.sv
// rtl/seq_multiplier32.sv - multi-cycle unsigned shift-and-add multiplier
// One multiplier bit per clock; the product register updates only on completion.
module seq_multiplier32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic               last;

  // acc[WIDTH] is always zero after a shift, so adding the full acc is exact
  always_comb begin
    sum     = acc + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    shifted = {sum, mplier} >> 1;
    last    = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= shifted[2*WIDTH:WIDTH];
          mplier <= shifted[WIDTH-1:0];
          count  <= count + 1'b1;
          if (last) product <= shifted[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
